// File: rtl/gsu_register_read_port.sv
// Byte-wide host read port onto a 16-bit register file.
//
// A low-byte read fetches the full register and keeps its high byte in a snapshot.
// A following high-byte read of the same register is then served from that snapshot,
// so the host sees a coherent 16-bit value even if the register changes between the
// two byte reads. The snapshot expires after SNAP_TIMEOUT cycles and is consumed by
// any high-byte read.
//
// Ports:
//   clk        single clock, all state changes on posedge
//   reset      asynchronous active-high reset
//   read_req   host read strobe, one cycle per read
//   read_addr  [4:1] register index, [0] byte select (0 low, 1 high)
//   sel_reg    register index presented to the register file
//   sel_data   register file contents for sel_reg (combinational)
//   read_data  returned byte, held while read_valid is low
//   read_valid one-cycle pulse qualifying read_data
//   busy       high whenever the FSM is not idle
//   overrun    sticky flag, set when a request arrives while busy
module gsu_register_read_port #(
  parameter int unsigned SNAP_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        read_req,
  input  logic [4:0]  read_addr,
  output logic [3:0]  sel_reg,
  input  logic [15:0] sel_data,
  output logic [7:0]  read_data,
  output logic        read_valid,
  output logic        busy,
  output logic        overrun
);

  localparam logic [7:0] SnapInit = 8'(SNAP_TIMEOUT);

  typedef enum logic [1:0] {StIdle, StFetch, StRespond} state_e;

  state_e      state_q, state_d;
  logic [3:0]  sel_reg_q, sel_reg_d;
  logic [7:0]  read_data_q, read_data_d;
  logic        read_valid_q, read_valid_d;
  logic        overrun_q, overrun_d;
  logic        fetch_high_q, fetch_high_d;  // byte select of the read in flight
  logic        snap_valid_q, snap_valid_d;
  logic [3:0]  snap_index_q, snap_index_d;
  logic [7:0]  snap_high_q, snap_high_d;
  logic [7:0]  snap_count_q, snap_count_d;

  logic       accept;
  logic       req_high;
  logic [3:0] req_index;
  logic       hit;
  logic       snap_load;

  always_comb begin
    accept    = read_req && (state_q == StIdle);
    req_high  = read_addr[0];
    req_index = read_addr[4:1];
    // Registered snap_valid is used, so a request on the expiry edge still hits.
    hit       = accept && req_high && snap_valid_q && (snap_index_q == req_index);
    snap_load = (state_q == StFetch) && !fetch_high_q;

    state_d      = state_q;
    sel_reg_d    = sel_reg_q;
    read_data_d  = read_data_q;
    read_valid_d = 1'b0;
    fetch_high_d = fetch_high_q;
    overrun_d    = overrun_q | (read_req && (state_q != StIdle));

    case (state_q)
      StIdle: begin
        if (hit) begin
          state_d      = StRespond;
          read_data_d  = snap_high_q;
          read_valid_d = 1'b1;
        end else if (accept) begin
          state_d      = StFetch;
          sel_reg_d    = req_index;
          fetch_high_d = req_high;
        end
      end
      StFetch: begin
        state_d      = StRespond;
        read_data_d  = fetch_high_q ? sel_data[15:8] : sel_data[7:0];
        read_valid_d = 1'b1;
      end
      StRespond: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    snap_valid_d = snap_valid_q;
    snap_index_d = snap_index_q;
    snap_high_d  = snap_high_q;
    snap_count_d = snap_count_q;
    if (snap_load) begin
      snap_valid_d = 1'b1;
      snap_index_d = sel_reg_q;
      snap_high_d  = sel_data[15:8];
      snap_count_d = SnapInit;
    end else begin
      if (snap_valid_q) begin
        snap_count_d = snap_count_q - 8'd1;
        if (snap_count_q == 8'd1) begin
          snap_valid_d = 1'b0;
        end
      end
      // Any accepted high-byte read, hit or miss, consumes the snapshot.
      if (accept && req_high) begin
        snap_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      sel_reg_q    <= 4'd0;
      read_data_q  <= 8'h00;
      read_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
      fetch_high_q <= 1'b0;
      snap_valid_q <= 1'b0;
      snap_index_q <= 4'd0;
      snap_high_q  <= 8'h00;
      snap_count_q <= 8'd0;
    end else begin
      state_q      <= state_d;
      sel_reg_q    <= sel_reg_d;
      read_data_q  <= read_data_d;
      read_valid_q <= read_valid_d;
      overrun_q    <= overrun_d;
      fetch_high_q <= fetch_high_d;
      snap_valid_q <= snap_valid_d;
      snap_index_q <= snap_index_d;
      snap_high_q  <= snap_high_d;
      snap_count_q <= snap_count_d;
    end
  end

  assign sel_reg    = sel_reg_q;
  assign read_data  = read_data_q;
  assign read_valid = read_valid_q;
  assign busy       = (state_q != StIdle);
  assign overrun    = overrun_q;

endmodule
